// File: rtl/bp_zynq_bedrock_axi4_bridge.sv
// BedRock memory-forward/reverse to AXI4 master bridge for the unicore ZynqParrot BlackParrot.
// One transaction in flight; BP DRAM window addresses are rebased into the AXI window.
module bp_zynq_bedrock_axi4_bridge #(
  parameter int unsigned paddr_width_p = 34,
  parameter int unsigned data_width_p = 64,
  parameter int unsigned axi_addr_width_p = 32,
  parameter int unsigned axi_id_width_p = 1,
  parameter logic [paddr_width_p-1:0] dram_base_p = 34'h0_8000_0000,
  parameter logic [axi_addr_width_p-1:0] axi_base_p = 32'h1000_0000,
  parameter int unsigned max_beats_p = 8
) (
  input  logic                        aclk,
  input  logic                        aresetn,

  input  logic                        mem_fwd_v_i,
  output logic                        mem_fwd_ready_and_o,
  input  logic [3:0]                  mem_fwd_msg_type_i,
  input  logic [paddr_width_p-1:0]    mem_fwd_addr_i,
  input  logic [2:0]                  mem_fwd_size_i,
  input  logic [31:0]                 mem_fwd_payload_i,
  input  logic [data_width_p-1:0]     mem_fwd_data_i,
  input  logic                        mem_fwd_last_i,

  output logic                        mem_rev_v_o,
  input  logic                        mem_rev_ready_and_i,
  output logic [3:0]                  mem_rev_msg_type_o,
  output logic [paddr_width_p-1:0]    mem_rev_addr_o,
  output logic [2:0]                  mem_rev_size_o,
  output logic [31:0]                 mem_rev_payload_o,
  output logic [data_width_p-1:0]     mem_rev_data_o,
  output logic                        mem_rev_last_o,

  output logic [axi_addr_width_p-1:0] m_axi_awaddr,
  output logic [7:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic [axi_id_width_p-1:0]   m_axi_awid,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,

  output logic [data_width_p-1:0]     m_axi_wdata,
  output logic [data_width_p/8-1:0]   m_axi_wstrb,
  output logic                        m_axi_wlast,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,

  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,

  output logic [axi_addr_width_p-1:0] m_axi_araddr,
  output logic [7:0]                  m_axi_arlen,
  output logic [2:0]                  m_axi_arsize,
  output logic [1:0]                  m_axi_arburst,
  output logic [axi_id_width_p-1:0]   m_axi_arid,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,

  input  logic [data_width_p-1:0]     m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rlast,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready,

  output logic                        error_o
);

  localparam int unsigned strb_width_lp = data_width_p / 8;

  typedef enum logic [3:0] {
    IDLE, RD_AR, RD_DATA, WR_AW, WR_DATA, WR_B, WR_REV, ERR_DRAIN, ERR_REV
  } state_e;

  state_e state_q, state_n;

  logic [3:0]                  type_q;
  logic [paddr_width_p-1:0]    addr_q;
  logic [2:0]                  size_q;
  logic [31:0]                 payload_q;
  logic [axi_addr_width_p-1:0] axaddr_q;
  logic [7:0]                  axlen_q;
  logic [2:0]                  axsize_q;
  logic [strb_width_lp-1:0]    strb_q;
  logic [data_width_p-1:0]     wbuf_q;
  logic                        wbuf_v_q;
  logic [8:0]                  load_cnt_q;
  logic [7:0]                  w_cnt_q;
  logic                        w_done_q;
  logic                        fwd_done_q;
  logic                        error_q;
  logic                        live_q;

  logic [8:0]                  hdr_beats;
  logic [7:0]                  hdr_len;
  logic [2:0]                  hdr_axsize;
  logic [axi_addr_width_p-1:0] hdr_axaddr;
  logic [strb_width_lp-1:0]    hdr_strb;

  logic w_phase, w_hs, need_data, fwd_ready, fwd_hs;

  // Burst shape, rebased address and byte strobe derived from the incoming header
  always_comb begin
    hdr_beats = 9'd1;
    if (mem_fwd_size_i > 3'd3) hdr_beats = 9'd1 << (mem_fwd_size_i - 3'd3);
    if (hdr_beats > 9'(max_beats_p)) hdr_beats = 9'(max_beats_p);
    hdr_len    = 8'(hdr_beats - 9'd1);
    hdr_axsize = (mem_fwd_size_i > 3'd3) ? 3'd3 : mem_fwd_size_i;
    hdr_axaddr = axi_addr_width_p'(mem_fwd_addr_i - dram_base_p) + axi_base_p;
    if (mem_fwd_size_i >= 3'd3) hdr_axaddr[2:0] = 3'b000;
    hdr_strb = '1;
    if (mem_fwd_size_i < 3'd3)
      hdr_strb = strb_width_lp'(((16'd1 << (16'd1 << mem_fwd_size_i)) - 16'd1)
                                << mem_fwd_addr_i[2:0]);
  end

  // Write-data staging: the buffer refills while it drains; surplus forward beats are dropped
  always_comb begin
    w_phase   = (state_q == WR_AW) || (state_q == WR_DATA);
    w_hs      = w_phase && wbuf_v_q && m_axi_wready;
    need_data = (load_cnt_q <= 9'(axlen_q));
    fwd_ready = 1'b0;
    case (state_q)
      IDLE:           fwd_ready = live_q;
      ERR_DRAIN:      fwd_ready = 1'b1;
      WR_AW, WR_DATA: fwd_ready = need_data ? (!wbuf_v_q || w_hs) : !fwd_done_q;
      default:        fwd_ready = 1'b0;
    endcase
    fwd_hs = mem_fwd_v_i && fwd_ready;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_n;
  end

  always_comb begin
    state_n        = state_q;
    mem_rev_v_o    = 1'b0;
    mem_rev_last_o = 1'b0;
    mem_rev_data_o = '0;
    m_axi_arvalid  = 1'b0;
    m_axi_awvalid  = 1'b0;
    m_axi_wvalid   = 1'b0;
    m_axi_bready   = 1'b0;
    m_axi_rready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fwd_hs) begin
          if (mem_fwd_msg_type_i == 4'd0)      state_n = RD_AR;
          else if (mem_fwd_msg_type_i == 4'd1) state_n = WR_AW;
          else if (mem_fwd_last_i)             state_n = ERR_REV;
          else                                 state_n = ERR_DRAIN;
        end
      end
      RD_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_n = RD_DATA;
      end
      RD_DATA: begin
        m_axi_rready   = mem_rev_ready_and_i;
        mem_rev_v_o    = m_axi_rvalid;
        mem_rev_data_o = m_axi_rdata;
        mem_rev_last_o = m_axi_rlast;
        if (m_axi_rvalid && mem_rev_ready_and_i && m_axi_rlast) state_n = IDLE;
      end
      WR_AW: begin
        m_axi_awvalid = 1'b1;
        m_axi_wvalid  = wbuf_v_q;
        if (m_axi_awready) state_n = WR_DATA;
      end
      WR_DATA: begin
        m_axi_wvalid = wbuf_v_q;
        if (w_done_q && fwd_done_q) state_n = WR_B;
      end
      WR_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_n = WR_REV;
      end
      WR_REV, ERR_REV: begin
        mem_rev_v_o    = 1'b1;
        mem_rev_last_o = 1'b1;
        if (mem_rev_ready_and_i) state_n = IDLE;
      end
      ERR_DRAIN: begin
        if (mem_fwd_v_i && mem_fwd_last_i) state_n = ERR_REV;
      end
      default: state_n = IDLE;
    endcase
  end

  // Header capture, write buffer, beat counters and sticky error
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      type_q     <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      payload_q  <= '0;
      axaddr_q   <= '0;
      axlen_q    <= '0;
      axsize_q   <= '0;
      strb_q     <= '0;
      wbuf_q     <= '0;
      wbuf_v_q   <= 1'b0;
      load_cnt_q <= '0;
      w_cnt_q    <= '0;
      w_done_q   <= 1'b0;
      fwd_done_q <= 1'b0;
      error_q    <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (state_q == IDLE && fwd_hs) begin
        type_q     <= mem_fwd_msg_type_i;
        addr_q     <= mem_fwd_addr_i;
        size_q     <= mem_fwd_size_i;
        payload_q  <= mem_fwd_payload_i;
        axaddr_q   <= hdr_axaddr;
        axlen_q    <= hdr_len;
        axsize_q   <= hdr_axsize;
        strb_q     <= hdr_strb;
        wbuf_q     <= mem_fwd_data_i;
        wbuf_v_q   <= (mem_fwd_msg_type_i == 4'd1);
        load_cnt_q <= 9'd1;
        w_cnt_q    <= '0;
        w_done_q   <= 1'b0;
        fwd_done_q <= mem_fwd_last_i;
        if (mem_fwd_msg_type_i > 4'd1) error_q <= 1'b1;
      end
      if (w_hs) begin
        w_cnt_q  <= w_cnt_q + 8'd1;
        wbuf_v_q <= 1'b0;
        if (w_cnt_q == axlen_q) w_done_q <= 1'b1;
      end
      if (w_phase && fwd_hs) begin
        fwd_done_q <= fwd_done_q | mem_fwd_last_i;
        if (need_data) begin
          wbuf_q     <= mem_fwd_data_i;
          wbuf_v_q   <= 1'b1;
          load_cnt_q <= load_cnt_q + 9'd1;
        end
      end
      if (state_q == RD_DATA && m_axi_rvalid && mem_rev_ready_and_i && m_axi_rresp != 2'b00)
        error_q <= 1'b1;
      if (state_q == WR_B && m_axi_bvalid && m_axi_bresp != 2'b00)
        error_q <= 1'b1;
    end
  end

  assign mem_fwd_ready_and_o = fwd_ready;
  assign mem_rev_msg_type_o  = type_q;
  assign mem_rev_addr_o      = addr_q;
  assign mem_rev_size_o      = size_q;
  assign mem_rev_payload_o   = payload_q;

  assign m_axi_awaddr  = axaddr_q;
  assign m_axi_awlen   = axlen_q;
  assign m_axi_awsize  = axsize_q;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awid    = '0;
  assign m_axi_wdata   = wbuf_q;
  assign m_axi_wstrb   = strb_q;
  assign m_axi_wlast   = (w_cnt_q == axlen_q);
  assign m_axi_araddr  = axaddr_q;
  assign m_axi_arlen   = axlen_q;
  assign m_axi_arsize  = axsize_q;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arid    = '0;
  assign error_o       = error_q;

endmodule

// File: tb/tb_bp_zynq_bedrock_axi4_bridge.sv
// Directed bench for the BedRock-to-AXI4 bridge: bus monitors record handshakes,
// directed transactions check them against hand-computed values.
module tb_bp_zynq_bedrock_axi4_bridge;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic        mem_fwd_v_i, mem_fwd_ready_and_o;
  logic [3:0]  mem_fwd_msg_type_i;
  logic [33:0] mem_fwd_addr_i;
  logic [2:0]  mem_fwd_size_i;
  logic [31:0] mem_fwd_payload_i;
  logic [63:0] mem_fwd_data_i;
  logic        mem_fwd_last_i;
  logic        mem_rev_v_o, mem_rev_ready_and_i;
  logic [3:0]  mem_rev_msg_type_o;
  logic [33:0] mem_rev_addr_o;
  logic [2:0]  mem_rev_size_o;
  logic [31:0] mem_rev_payload_o;
  logic [63:0] mem_rev_data_o;
  logic        mem_rev_last_o;
  logic [31:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic [2:0]  m_axi_awsize, m_axi_arsize;
  logic [1:0]  m_axi_awburst, m_axi_arburst;
  logic [0:0]  m_axi_awid, m_axi_arid;
  logic        m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [63:0] m_axi_wdata, m_axi_rdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic        error_o;

  bp_zynq_bedrock_axi4_bridge dut (
    .aclk(aclk), .aresetn(aresetn),
    .mem_fwd_v_i(mem_fwd_v_i), .mem_fwd_ready_and_o(mem_fwd_ready_and_o),
    .mem_fwd_msg_type_i(mem_fwd_msg_type_i), .mem_fwd_addr_i(mem_fwd_addr_i),
    .mem_fwd_size_i(mem_fwd_size_i), .mem_fwd_payload_i(mem_fwd_payload_i),
    .mem_fwd_data_i(mem_fwd_data_i), .mem_fwd_last_i(mem_fwd_last_i),
    .mem_rev_v_o(mem_rev_v_o), .mem_rev_ready_and_i(mem_rev_ready_and_i),
    .mem_rev_msg_type_o(mem_rev_msg_type_o), .mem_rev_addr_o(mem_rev_addr_o),
    .mem_rev_size_o(mem_rev_size_o), .mem_rev_payload_o(mem_rev_payload_o),
    .mem_rev_data_o(mem_rev_data_o), .mem_rev_last_o(mem_rev_last_o),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awid(m_axi_awid),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arid(m_axi_arid),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .error_o(error_o)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {mem_fwd_ready_and_o, mem_rev_v_o, m_axi_arvalid, m_axi_awvalid,
            m_axi_wvalid, m_axi_bready, m_axi_rready, error_o};
  endfunction

  // Handshake logs, sampled on the falling edge
  int ar_n = 0, aw_n = 0, w_n = 0, rev_n = 0;
  logic [31:0] ar_addr_a [256];
  logic [7:0]  ar_len_a  [256];
  logic [2:0]  ar_size_a [256];
  logic [31:0] aw_addr_a [256];
  logic [7:0]  aw_len_a  [256];
  logic [2:0]  aw_size_a [256];
  logic [63:0] w_data_a  [256];
  logic [7:0]  w_strb_a  [256];
  logic        w_last_a  [256];
  logic [63:0] rev_data_a[256];
  logic        rev_last_a[256];
  logic [31:0] rev_pay_a [256];
  logic [3:0]  rev_type_a[256];
  logic [33:0] rev_addr_a[256];

  initial forever begin
    @(negedge aclk);
    if (m_axi_arvalid && m_axi_arready) begin
      ar_addr_a[8'(ar_n)] = m_axi_araddr; ar_len_a[8'(ar_n)] = m_axi_arlen;
      ar_size_a[8'(ar_n)] = m_axi_arsize; ar_n++;
    end
    if (m_axi_awvalid && m_axi_awready) begin
      aw_addr_a[8'(aw_n)] = m_axi_awaddr; aw_len_a[8'(aw_n)] = m_axi_awlen;
      aw_size_a[8'(aw_n)] = m_axi_awsize; aw_n++;
    end
    if (m_axi_wvalid && m_axi_wready) begin
      w_data_a[8'(w_n)] = m_axi_wdata; w_strb_a[8'(w_n)] = m_axi_wstrb;
      w_last_a[8'(w_n)] = m_axi_wlast; w_n++;
    end
    if (mem_rev_v_o && mem_rev_ready_and_i) begin
      rev_data_a[8'(rev_n)] = mem_rev_data_o; rev_last_a[8'(rev_n)] = mem_rev_last_o;
      rev_pay_a[8'(rev_n)] = mem_rev_payload_o; rev_type_a[8'(rev_n)] = mem_rev_msg_type_o;
      rev_addr_a[8'(rev_n)] = mem_rev_addr_o; rev_n++;
    end
  end

  task automatic fwd_send(input logic [3:0] t, input logic [33:0] a, input logic [2:0] s,
                          input logic [31:0] p, input int nb, input logic [63:0] d0,
                          input string tag);
    int acc = 0;
    logic hs;
    for (int i = 0; i < nb; i++) begin
      mem_fwd_v_i = 1'b1; mem_fwd_msg_type_i = t; mem_fwd_addr_i = a;
      mem_fwd_size_i = s; mem_fwd_payload_i = p; mem_fwd_data_i = d0 + 64'(i);
      mem_fwd_last_i = (i == nb - 1);
      hs = 1'b0;
      for (int c = 0; c < 200 && !hs; c++) begin
        @(negedge aclk); hs = mem_fwd_ready_and_o;
        @(posedge aclk); #1;
      end
      if (hs) acc++;
    end
    mem_fwd_v_i = 1'b0; mem_fwd_last_i = 1'b0;
    check({tag, "_fwd_beats"}, 64'(acc), 64'(nb));
  endtask

  task automatic r_send(input int len, input int cnt, input logic [63:0] base, input int err_idx);
    int sent = 0;
    logic hs;
    for (int i = 0; i < cnt; i++) begin
      m_axi_rvalid = 1'b1; m_axi_rdata = base + 64'(i);
      m_axi_rresp = (i == err_idx) ? 2'b10 : 2'b00;
      m_axi_rlast = (i == len - 1);
      hs = 1'b0;
      for (int c = 0; c < 200 && !hs; c++) begin
        @(negedge aclk); hs = m_axi_rready;
        @(posedge aclk); #1;
      end
      if (hs) sent++;
    end
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
    check("r_beats", 64'(sent), 64'(cnt));
  endtask

  task automatic b_send(input logic [1:0] resp);
    logic hs = 1'b0;
    m_axi_bvalid = 1'b1; m_axi_bresp = resp;
    for (int c = 0; c < 200 && !hs; c++) begin
      @(negedge aclk); hs = m_axi_bready;
      @(posedge aclk); #1;
    end
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    check("b_handshake", 64'(hs), 64'd1);
  endtask

  task automatic wait_ar(input int target, input string tag);
    for (int c = 0; c < 300 && ar_n < target; c++) begin @(posedge aclk); #1; end
    check(tag, 64'(ar_n), 64'(target));
  endtask

  task automatic wait_w(input int target, input string tag);
    for (int c = 0; c < 400 && w_n < target; c++) begin @(posedge aclk); #1; end
    check(tag, 64'(w_n), 64'(target));
  endtask

  task automatic wait_rev(input int target, input string tag);
    for (int c = 0; c < 300 && rev_n < target; c++) begin @(posedge aclk); #1; end
    check(tag, 64'(rev_n), 64'(target));
  endtask

  int ar0, aw0, w0, rv0, axi0, chg;
  logic [7:0]  lm, sa;
  logic [97:0] snap;

  initial begin
    aresetn = 1'b0;
    mem_fwd_v_i = 0; mem_fwd_msg_type_i = 0; mem_fwd_addr_i = 0; mem_fwd_size_i = 0;
    mem_fwd_payload_i = 0; mem_fwd_data_i = 0; mem_fwd_last_i = 0;
    mem_rev_ready_and_i = 1; m_axi_awready = 1; m_axi_wready = 1; m_axi_arready = 1;
    m_axi_bresp = 0; m_axi_bvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    m_axi_rlast = 0; m_axi_rvalid = 0;

    // Reset state and release latency
    repeat (3) @(posedge aclk);
    #1 check("rst_outs", 64'(outs()), 64'd0);
    aresetn = 1'b1;
    @(negedge aclk); check("rel_ready_lag", 64'(mem_fwd_ready_and_o), 64'd0);
    @(posedge aclk); #1 check("rel_ready", 64'(mem_fwd_ready_and_o), 64'd1);

    // 64 B read burst
    ar0 = ar_n; rv0 = rev_n;
    fork
      fwd_send(4'd0, 34'h0_8000_0040, 3'd6, 32'hCAFE_0001, 1, 64'd0, "t1");
      begin wait_ar(ar0 + 1, "t1_ar"); r_send(8, 8, 64'hA0, -1); end
    join
    wait_rev(rv0 + 8, "t1_rev_n");
    check("t1_araddr", 64'(ar_addr_a[8'(ar0)]), 64'h1000_0040);
    check("t1_arlen", 64'(ar_len_a[8'(ar0)]), 64'd7);
    check("t1_arsize", 64'(ar_size_a[8'(ar0)]), 64'd3);
    for (int i = 0; i < 8; i++) begin
      check("t1_rdata", rev_data_a[8'(rv0 + i)], 64'hA0 + 64'(i));
      lm[i] = rev_last_a[8'(rv0 + i)];
    end
    check("t1_last", 64'(lm), 64'h80);
    check("t1_pay0", 64'(rev_pay_a[8'(rv0)]), 64'hCAFE_0001);
    check("t1_pay7", 64'(rev_pay_a[8'(rv0 + 7)]), 64'hCAFE_0001);
    check("t1_addr", 64'(rev_addr_a[8'(rv0)]), 64'h0_8000_0040);
    check("t1_err", 64'(error_o), 64'd0);

    // Sub-word write
    aw0 = aw_n; w0 = w_n; rv0 = rev_n;
    fork
      fwd_send(4'd1, 34'h0_8000_0104, 3'd2, 32'hCAFE_0002, 1, 64'hDEADBEEF_00000000, "t2");
      begin wait_w(w0 + 1, "t2_w_n"); b_send(2'b00); end
    join
    wait_rev(rv0 + 1, "t2_rev_n");
    check("t2_awaddr", 64'(aw_addr_a[8'(aw0)]), 64'h1000_0104);
    check("t2_awlen", 64'(aw_len_a[8'(aw0)]), 64'd0);
    check("t2_awsize", 64'(aw_size_a[8'(aw0)]), 64'd2);
    check("t2_wstrb", 64'(w_strb_a[8'(w0)]), 64'hF0);
    check("t2_wlast", 64'(w_last_a[8'(w0)]), 64'd1);
    check("t2_wdata", w_data_a[8'(w0)], 64'hDEADBEEF_00000000);
    check("t2_rev_data", rev_data_a[8'(rv0)], 64'd0);
    check("t2_rev_last", 64'(rev_last_a[8'(rv0)]), 64'd1);
    check("t2_rev_type", 64'(rev_type_a[8'(rv0)]), 64'd1);
    check("t2_err", 64'(error_o), 64'd0);

    // 64 B write with AW delayed, W ready toggling, reverse ready held low
    aw0 = aw_n; w0 = w_n; rv0 = rev_n;
    mem_rev_ready_and_i = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    fork
      fwd_send(4'd1, 34'h0_8000_0200, 3'd6, 32'hCAFE_0003, 8, 64'h1000, "t3");
      begin repeat (4) @(posedge aclk); #1 m_axi_awready = 1'b1; end
      begin
        for (int c = 0; c < 400 && w_n < w0 + 8; c++) begin
          @(posedge aclk); #1 m_axi_wready = ~m_axi_wready;
        end
      end
    join
    m_axi_wready = 1'b1;
    wait_w(w0 + 8, "t3_w_n");
    b_send(2'b00);
    for (int c = 0; c < 50 && !mem_rev_v_o; c++) @(negedge aclk);
    check("t3_rev_v", 64'(mem_rev_v_o), 64'd1);
    snap = {mem_rev_data_o, mem_rev_last_o, mem_rev_payload_o, mem_rev_v_o};
    chg = 0;
    repeat (5) begin
      @(negedge aclk);
      if ({mem_rev_data_o, mem_rev_last_o, mem_rev_payload_o, mem_rev_v_o} !== snap) chg++;
    end
    check("t3_rev_hold", 64'(chg), 64'd0);
    check("t3_rev_waiting", 64'(rev_n), 64'(rv0));
    @(posedge aclk); #1 mem_rev_ready_and_i = 1'b1;
    wait_rev(rv0 + 1, "t3_rev_n");
    check("t3_aw_n", 64'(aw_n - aw0), 64'd1);
    check("t3_awaddr", 64'(aw_addr_a[8'(aw0)]), 64'h1000_0200);
    check("t3_awlen", 64'(aw_len_a[8'(aw0)]), 64'd7);
    sa = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      check("t3_wdata", w_data_a[8'(w0 + i)], 64'h1000 + 64'(i));
      lm[i] = w_last_a[8'(w0 + i)];
      sa = sa & w_strb_a[8'(w0 + i)];
    end
    check("t3_wlast", 64'(lm), 64'h80);
    check("t3_wstrb", 64'(sa), 64'hFF);
    check("t3_rev_data", rev_data_a[8'(rv0)], 64'd0);
    check("t3_rev_last", 64'(rev_last_a[8'(rv0)]), 64'd1);

    // Read with SLVERR on the third beat, then an OKAY unaligned byte read
    ar0 = ar_n; rv0 = rev_n;
    fork
      fwd_send(4'd0, 34'h0_8000_0080, 3'd6, 32'hCAFE_0004, 1, 64'd0, "t4");
      begin wait_ar(ar0 + 1, "t4_ar"); r_send(8, 8, 64'hB0, 2); end
    join
    wait_rev(rv0 + 8, "t4_rev_n");
    check("t4_araddr", 64'(ar_addr_a[8'(ar0)]), 64'h1000_0080);
    check("t4_beat3", rev_data_a[8'(rv0 + 2)], 64'hB2);
    check("t4_beat8", rev_data_a[8'(rv0 + 7)], 64'hB7);
    check("t4_last", 64'(rev_last_a[8'(rv0 + 7)]), 64'd1);
    check("t4_err", 64'(error_o), 64'd1);
    ar0 = ar_n; rv0 = rev_n;
    fork
      fwd_send(4'd0, 34'h0_8000_0013, 3'd0, 32'hCAFE_0014, 1, 64'd0, "t4b");
      begin wait_ar(ar0 + 1, "t4b_ar"); r_send(1, 1, 64'h5A, -1); end
    join
    wait_rev(rv0 + 1, "t4b_rev_n");
    check("t4b_araddr", 64'(ar_addr_a[8'(ar0)]), 64'h1000_0013);
    check("t4b_arlen", 64'(ar_len_a[8'(ar0)]), 64'd0);
    check("t4b_arsize", 64'(ar_size_a[8'(ar0)]), 64'd0);
    check("t4b_data", rev_data_a[8'(rv0)], 64'h5A);
    check("t4b_err_sticky", 64'(error_o), 64'd1);

    // Unsupported message type with two forward beats
    axi0 = ar_n + aw_n + w_n; rv0 = rev_n;
    fwd_send(4'd3, 34'h0_8000_0300, 3'd3, 32'hCAFE_0005, 2, 64'h77, "t5");
    wait_rev(rv0 + 1, "t5_rev_n");
    check("t5_no_axi", 64'(ar_n + aw_n + w_n - axi0), 64'd0);
    check("t5_rev_data", rev_data_a[8'(rv0)], 64'd0);
    check("t5_rev_last", 64'(rev_last_a[8'(rv0)]), 64'd1);
    check("t5_rev_type", 64'(rev_type_a[8'(rv0)]), 64'd3);
    check("t5_rev_pay", 64'(rev_pay_a[8'(rv0)]), 64'hCAFE_0005);
    check("t5_err", 64'(error_o), 64'd1);

    // Reset during a read burst, then a clean read
    ar0 = ar_n; rv0 = rev_n;
    fork
      fwd_send(4'd0, 34'h0_8000_0400, 3'd6, 32'hCAFE_0006, 1, 64'd0, "t6");
      begin wait_ar(ar0 + 1, "t6_ar"); r_send(8, 2, 64'hD0, -1); end
    join
    check("t6_beats_pre", 64'(rev_n - rv0), 64'd2);
    check("t6_rready_pre", 64'(m_axi_rready), 64'd1);
    aresetn = 1'b0;
    #1 check("t6_rst_outs", 64'(outs()), 64'd0);
    @(posedge aclk); #1 aresetn = 1'b1;
    @(posedge aclk); #1;
    check("t6_no_rev_after_rst", 64'(rev_n - rv0), 64'd2);
    ar0 = ar_n; rv0 = rev_n;
    fork
      fwd_send(4'd0, 34'h0_8000_0008, 3'd3, 32'hCAFE_0007, 1, 64'd0, "t6b");
      begin wait_ar(ar0 + 1, "t6b_ar"); r_send(1, 1, 64'hE0, -1); end
    join
    wait_rev(rv0 + 1, "t6b_rev_n");
    check("t6b_araddr", 64'(ar_addr_a[8'(ar0)]), 64'h1000_0008);
    check("t6b_arlen", 64'(ar_len_a[8'(ar0)]), 64'd0);
    check("t6b_arsize", 64'(ar_size_a[8'(ar0)]), 64'd3);
    check("t6b_data", rev_data_a[8'(rv0)], 64'hE0);
    check("t6b_last", 64'(rev_last_a[8'(rv0)]), 64'd1);
    check("t6b_err", 64'(error_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/bp_zynq_bedrock_axi4_bridge.md
Name: bp_zynq_bedrock_axi4_bridge

Overview:
- Sits directly downstream of the unicore ZynqParrot BlackParrot configuration: 34-bit paddr, 64-bit BedRock fill width, single L2 slice and bank.
- Consumes the core's BedRock memory-forward stream and issues AXI4 master transactions toward the Zynq HP port/DRAM.
- Returns the matching BedRock memory-reverse stream.
- One transaction outstanding at a time; address is rebased from the BP DRAM window into the AXI window.

Parameters:
- paddr_width_p, 34, BedRock physical address width.
- data_width_p, 64, BedRock beat width and AXI data width.
- axi_addr_width_p, 32, AXI address width.
- axi_id_width_p, 1, AXI ID width.
- dram_base_p, 34'h0_8000_0000, BP address mapped to AXI offset 0.
- axi_base_p, 32'h1000_0000, AXI address corresponding to dram_base_p.
- max_beats_p, 8, largest burst in beats (64 B block).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- mem_fwd_v_i  in  1  forward beat valid.
- mem_fwd_ready_and_o  out  1  forward beat accepted when v&ready.
- mem_fwd_msg_type_i  in  4  0=read, 1=write, others unsupported; sampled on first beat.
- mem_fwd_addr_i  in  paddr_width_p  byte address; sampled on first beat.
- mem_fwd_size_i  in  3  log2 bytes (0..6); sampled on first beat.
- mem_fwd_payload_i  in  32  opaque header payload; echoed in the response.
- mem_fwd_data_i  in  data_width_p  write data beat.
- mem_fwd_last_i  in  1  last forward beat.
- mem_rev_v_o  out  1  reverse beat valid.
- mem_rev_ready_and_i  in  1  reverse beat accepted.
- mem_rev_msg_type_o, mem_rev_addr_o, mem_rev_size_o, mem_rev_payload_o  out  4/34/3/32  echoed header.
- mem_rev_data_o  out  data_width_p  read data beat, or zero for writes.
- mem_rev_last_o  out  1  last reverse beat.
- m_axi_aw*  out  standard AXI4 AW channel (awaddr, awlen[7:0], awsize[2:0], awburst=INCR, awid=0, awvalid); awready in.
- m_axi_w*  out  wdata, wstrb[7:0], wlast, wvalid; wready in.
- m_axi_b*  in  bresp[1:0], bvalid; bready out.
- m_axi_ar*  out  araddr, arlen, arsize, arburst=INCR, arid=0, arvalid; arready in.
- m_axi_r*  in  rdata, rresp, rlast, rvalid; rready out.
- error_o  out  1  sticky: non-OKAY resp or unsupported msg_type.

Behaviour:
- Reset (aresetn low, async): state=IDLE; every valid and ready output is 0; error_o=0; beat counters=0. Reset asserted mid-transaction abandons it immediately, with no completion beat. Deasserting reset takes effect on the next aclk edge.
- FSM states: IDLE, RD_AR, RD_DATA, WR_AW, WR_DATA, WR_B, WR_REV, ERR_DRAIN, ERR_REV.
- IDLE:
  - mem_fwd_ready_and_o=1.
  - On the accepted first beat, register the header.
  - Read: fwd beat consumed, go to RD_AR.
  - Write: the first beat's data is also buffered; go to WR_AW.
  - Other type: set error_o. Go to ERR_REV if last, else ERR_DRAIN.
- Beat and size computation:
  - bytes = 1<<size.
  - beats = (size>3) ? bytes/8 : 1.
  - axlen = beats-1.
  - axsize = min(size,3).
- Address computation:
  - axaddr = (addr - dram_base_p + axi_base_p) truncated to axi_addr_width_p.
  - For size<3 the low bits are kept unaligned.
  - For size>=3 the low 3 bits are forced to 0.
- RD_AR: arvalid=1 until arready, then go to RD_DATA.
- RD_DATA:
  - rready = mem_rev_ready_and_i. Each R beat maps straight to one reverse beat: mem_rev_v_o=rvalid, no extra latency, header echoed every beat.
  - mem_rev_last_o = rlast.
  - rresp!=0 sets error_o; data is still forwarded.
  - After the rlast handshake, go to IDLE.
- WR_AW: awvalid=1 until awready, then go to WR_DATA. W may begin in the same cycle as AW: wvalid is raised in WR_AW as well, and the AW and W handshakes are tracked independently.
- WR_DATA:
  - wvalid=1 while a buffered beat is held; mem_fwd_ready_and_o=1 only when the buffer is empty or is draining this cycle.
  - wlast=1 on beat index axlen.
  - wstrb = all ones for size>=3, else ((1<<bytes)-1)<<addr[2:0].
  - If mem_fwd_last_i and the beat count disagree, the beat count governs; extra forward beats are drained.
  - After the wlast handshake, and once AW has completed, go to WR_B.
- WR_B: bready=1. bresp!=0 sets error_o. Go to WR_REV.
- WR_REV: one reverse beat, data=0, last=1. Hold until ready, then go to IDLE.
- ERR_DRAIN: accept forward beats until last, then go to ERR_REV.
- ERR_REV: one zero reverse beat, last=1. Hold until ready, then go to IDLE.
- All AXI and BedRock valids are held stable until handshake; no combinational path from ready to valid.
- A new forward header is never accepted before the previous reverse last handshake.

Test Plan:
- Read, size=6 at 0x0_8000_0040:
  - araddr=0x1000_0040, arlen=7, arsize=3.
  - 8 R beats 0xA0..0xA7 appear in order on mem_rev_data_o; last on beat 8; payload echoed.
- Write, size=2 at 0x0_8000_0104, data 0xDEADBEEF_00000000:
  - awaddr=0x1000_0104, awlen=0, wstrb=0xF0, wlast=1.
  - After bresp=OKAY: one reverse beat, data 0, last=1.
- Write, size=6, with mem_rev_ready_and_i low 5 cycles and wready toggling every other cycle:
  - Exactly 8 W beats, wlast only on the 8th.
  - Reverse beat held stable until ready.
- Read with rresp=SLVERR on beat 3 -> all beats still delivered; error_o=1 and stays 1 through later OKAY transactions.
- msg_type=3 with 2 forward beats -> both consumed; no AXI activity; one zero reverse beat; error_o=1.
- aresetn pulsed low during RD_DATA after beat 2 -> all valid and ready outputs 0 immediately. A following read completes normally.
